stopwatch_lap_core: RTL and testbench

//  Single-clock, parametrised stopwatch/countdown core: the successor to the EGO1 stopwatch logic.

---
 rtl/stopwatch_lap_core.sv | 202 ++++++++++++++++++++
 tb/tb_stopwatch_lap_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core
//   Single-clock stopwatch/countdown core with an internal tick prescaler,
//   a run/pause/alarm FSM, a show-ahead lap FIFO and sticky overflow flags.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start/stop/clear           1-cycle control pulses (clear > stop > start)
//   lap, lap_rd                1-cycle pulses: capture time / pop FIFO head
//   min_inc, hour_inc          1-cycle preset pulses (IDLE/PAUSE only)
//   cd_mode                    1 = countdown, latched on entry to RUN
//   hours..centisec            packed-BCD time
//   running, alarm, ovf        state flags, sticky count-up wrap flag
//   lap_data/count/empty/full  FIFO head {hh,mm,ss,cc} and occupancy
//   lap_lost                   sticky: lap dropped on a full FIFO
module stopwatch_lap_core #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned LAP_DEPTH = 8,
  parameter int unsigned HOUR_MAX  = 99
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         clear,
  input  logic                         lap,
  input  logic                         lap_rd,
  input  logic                         min_inc,
  input  logic                         hour_inc,
  input  logic                         cd_mode,
  output logic [7:0]                   hours,
  output logic [7:0]                   minutes,
  output logic [7:0]                   seconds,
  output logic [7:0]                   centisec,
  output logic                         running,
  output logic                         alarm,
  output logic                         ovf,
  output logic [31:0]                  lap_data,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_empty,
  output logic                         lap_full,
  output logic                         lap_lost
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam int unsigned AW  = $clog2(LAP_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [7:0] HMAX_BCD = 8'(((HOUR_MAX / 10) * 16) + (HOUR_MAX % 10));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic            r_mode;
  logic [7:0]      r_hh, r_mm, r_ss, r_cc;
  logic            r_ovf, r_lost;
  logic [31:0]     r_mem [LAP_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
    if (v == maxv)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] maxv);
    if (v == 8'h00)          return maxv;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic w_time_zero, w_count_en, w_tick, w_edit, w_idle_start;
  logic [7:0] w_up_cc, w_up_ss, w_up_mm, w_up_hh;
  logic [7:0] w_dn_cc, w_dn_ss, w_dn_mm, w_dn_hh;
  logic w_cy_cc, w_cy_ss, w_cy_mm, w_up_wrap;
  logic w_bw_cc, w_bw_ss, w_bw_mm, w_dn_zero;
  logic w_push_req, w_pop, w_push;

  assign w_time_zero  = ({r_hh, r_mm, r_ss, r_cc} == '0);
  assign w_idle_start = start && !(cd_mode && w_time_zero);
  assign w_count_en   = (r_state == S_RUN) && !clear && !stop;
  assign w_tick       = w_count_en && (r_presc == PRESC_LAST);
  assign w_edit       = ((r_state == S_IDLE) || (r_state == S_PAUSE)) && !clear && !stop && !start;

  // Ripple chains: each stage advances only when every lower stage wraps.
  assign w_up_cc   = bcd_inc(r_cc, 8'h99);
  assign w_cy_cc   = (r_cc == 8'h99);
  assign w_up_ss   = w_cy_cc ? bcd_inc(r_ss, 8'h59) : r_ss;
  assign w_cy_ss   = w_cy_cc && (r_ss == 8'h59);
  assign w_up_mm   = w_cy_ss ? bcd_inc(r_mm, 8'h59) : r_mm;
  assign w_cy_mm   = w_cy_ss && (r_mm == 8'h59);
  assign w_up_hh   = w_cy_mm ? bcd_inc(r_hh, HMAX_BCD) : r_hh;
  assign w_up_wrap = w_cy_mm && (r_hh == HMAX_BCD);

  assign w_dn_cc   = bcd_dec(r_cc, 8'h99);
  assign w_bw_cc   = (r_cc == 8'h00);
  assign w_dn_ss   = w_bw_cc ? bcd_dec(r_ss, 8'h59) : r_ss;
  assign w_bw_ss   = w_bw_cc && (r_ss == 8'h00);
  assign w_dn_mm   = w_bw_ss ? bcd_dec(r_mm, 8'h59) : r_mm;
  assign w_bw_mm   = w_bw_ss && (r_mm == 8'h00);
  assign w_dn_hh   = w_bw_mm ? bcd_dec(r_hh, HMAX_BCD) : r_hh;
  assign w_dn_zero = ({w_dn_hh, w_dn_mm, w_dn_ss, w_dn_cc} == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (!stop && w_idle_start) w_state_nxt = S_RUN;
        S_RUN:   if (stop) w_state_nxt = S_PAUSE;
                 else if (w_tick && r_mode && w_dn_zero) w_state_nxt = S_ALARM;
        S_PAUSE: if (!stop && start) w_state_nxt = S_RUN;
        S_ALARM: if (stop || start) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_mode  <= 1'b0;
    end else if (clear) begin
      r_presc <= '0;
    end else begin
      if (r_state != S_RUN && w_state_nxt == S_RUN) r_mode <= cd_mode;
      // Resume from PAUSE keeps the held prescaler; only a fresh start zeroes it.
      if (r_state == S_IDLE && w_state_nxt == S_RUN) r_presc <= '0;
      else if (w_count_en)                          r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_hh, r_mm, r_ss, r_cc} <= '0;
      r_ovf <= 1'b0;
    end else if (clear) begin
      {r_hh, r_mm, r_ss, r_cc} <= '0;
      r_ovf <= 1'b0;
    end else if (w_tick) begin
      if (r_mode) begin
        {r_hh, r_mm, r_ss, r_cc} <= {w_dn_hh, w_dn_mm, w_dn_ss, w_dn_cc};
      end else begin
        {r_hh, r_mm, r_ss, r_cc} <= {w_up_hh, w_up_mm, w_up_ss, w_up_cc};
        if (w_up_wrap) r_ovf <= 1'b1;
      end
    end else if (w_edit) begin
      if (min_inc)  r_mm <= bcd_inc(r_mm, 8'h59);
      if (hour_inc) r_hh <= bcd_inc(r_hh, HMAX_BCD);
    end
  end

  assign w_push_req = lap && !clear && ((r_state == S_RUN) || (r_state == S_PAUSE));
  assign w_pop      = lap_rd && !clear && (r_count != '0);
  // A simultaneous pop frees the head slot, so a push on a full FIFO still fits.
  assign w_push     = w_push_req && ((r_count != CW'(LAP_DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_lost   <= 1'b0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_lost   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push_req && !w_push) r_lost <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_hh, r_mm, r_ss, r_cc};
  end

  assign hours     = r_hh;
  assign minutes   = r_mm;
  assign seconds   = r_ss;
  assign centisec  = r_cc;
  assign running   = (r_state == S_RUN);
  assign alarm     = (r_state == S_ALARM);
  assign ovf       = r_ovf;
  assign lap_count = r_count;
  assign lap_empty = (r_count == '0);
  assign lap_full  = (r_count == CW'(LAP_DEPTH));
  assign lap_lost  = r_lost;
  assign lap_data  = lap_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// tb_stopwatch_lap_core
//   Directed and randomized stimulus for stopwatch_lap_core, checked every
//   cycle against a reference model that keeps time as plain integers and
//   the lap FIFO as a queue.
module tb_stopwatch_lap_core;

  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned TICK_HZ   = 100;
  localparam int unsigned LAP_DEPTH = 4;
  localparam int unsigned HOUR_MAX  = 1;
  localparam int          DIV       = CLK_HZ / TICK_HZ;
  localparam int          LIMIT     = (HOUR_MAX + 1) * 360000;

  localparam int unsigned P_START = 1, P_STOP = 2, P_CLEAR = 4, P_LAP = 8;
  localparam int unsigned P_RD = 16, P_MIN = 32, P_HOUR = 64;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_ALARM = 3;

  logic clk = 1'b0;
  logic rst_n, start, stop, clear, lap, lap_rd, min_inc, hour_inc, cd_mode;
  logic [7:0] hours, minutes, seconds, centisec;
  logic running, alarm, ovf, lap_empty, lap_full, lap_lost;
  logic [31:0] lap_data;
  logic [2:0] lap_count;

  stopwatch_lap_core #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .LAP_DEPTH(LAP_DEPTH), .HOUR_MAX(HOUR_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .lap(lap), .lap_rd(lap_rd), .min_inc(min_inc), .hour_inc(hour_inc),
    .cd_mode(cd_mode), .hours(hours), .minutes(minutes), .seconds(seconds),
    .centisec(centisec), .running(running), .alarm(alarm), .ovf(ovf),
    .lap_data(lap_data), .lap_count(lap_count), .lap_empty(lap_empty),
    .lap_full(lap_full), .lap_lost(lap_lost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  int  m_st, m_h, m_m, m_s, m_c, m_ph;
  bit  m_mode, m_ovf, m_lost;
  logic [31:0] m_q[$];

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) * 16) + (n % 10));
  endfunction

  function automatic bit m_zero();
    return (m_h == 0) && (m_m == 0) && (m_s == 0) && (m_c == 0);
  endfunction

  task automatic m_reset();
    m_st = ST_IDLE; m_h = 0; m_m = 0; m_s = 0; m_c = 0; m_ph = 0;
    m_mode = 0; m_ovf = 0; m_lost = 0;
    m_q.delete();
  endtask

  task automatic m_set_cs(input int t);
    m_c = t % 100;
    m_s = (t / 100) % 60;
    m_m = (t / 6000) % 60;
    m_h = t / 360000;
  endtask

  task automatic m_tick();
    int t;
    t = ((m_h * 60 + m_m) * 60 + m_s) * 100 + m_c;
    if (!m_mode) begin
      t = t + 1;
      if (t == LIMIT) begin t = 0; m_ovf = 1; end
      m_set_cs(t);
    end else begin
      t = t - 1;
      m_set_cs(t);
      if (t == 0) m_st = ST_ALARM;
    end
  endtask

  task automatic m_edge(input int unsigned p, input bit cd);
    bit sp, st, zero, full0, push_req, pop;
    logic [31:0] entry;
    if ((p & P_CLEAR) != 0) begin
      m_reset();
      return;
    end
    sp = (p & P_STOP) != 0;
    st = (p & P_START) != 0;
    zero = m_zero();
    full0 = (m_q.size() == LAP_DEPTH);
    push_req = ((p & P_LAP) != 0) && (m_st == ST_RUN || m_st == ST_PAUSE);
    pop = ((p & P_RD) != 0) && (m_q.size() != 0);
    entry = {bcd(m_h), bcd(m_m), bcd(m_s), bcd(m_c)};
    if (pop) void'(m_q.pop_front());
    if (push_req) begin
      if (!full0 || pop) m_q.push_back(entry);
      else m_lost = 1;
    end
    case (m_st)
      ST_IDLE, ST_PAUSE: begin
        if (!sp && st) begin
          if (m_st == ST_PAUSE) begin
            m_st = ST_RUN; m_mode = cd;
          end else if (!(cd && zero)) begin
            m_st = ST_RUN; m_mode = cd; m_ph = 0;
          end
        end else if (!sp && !st) begin
          if ((p & P_MIN) != 0)  m_m = (m_m + 1) % 60;
          if ((p & P_HOUR) != 0) m_h = (m_h + 1) % (HOUR_MAX + 1);
        end
      end
      ST_ALARM: if (sp || st) m_st = ST_IDLE;
      default: begin
        if (sp) m_st = ST_PAUSE;
        else if (m_ph == DIV - 1) begin m_ph = 0; m_tick(); end
        else m_ph = m_ph + 1;
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("hours",     {24'd0, hours},    {24'd0, bcd(m_h)});
    chk("minutes",   {24'd0, minutes},  {24'd0, bcd(m_m)});
    chk("seconds",   {24'd0, seconds},  {24'd0, bcd(m_s)});
    chk("centisec",  {24'd0, centisec}, {24'd0, bcd(m_c)});
    chk("running",   {31'd0, running},  {31'd0, m_st == ST_RUN});
    chk("alarm",     {31'd0, alarm},    {31'd0, m_st == ST_ALARM});
    chk("ovf",       {31'd0, ovf},      {31'd0, m_ovf});
    chk("lap_data",  lap_data,          (m_q.size() != 0) ? m_q[0] : 32'd0);
    chk("lap_count", {29'd0, lap_count}, 32'(m_q.size()));
    chk("lap_empty", {31'd0, lap_empty}, {31'd0, m_q.size() == 0});
    chk("lap_full",  {31'd0, lap_full},  {31'd0, m_q.size() == LAP_DEPTH});
    chk("lap_lost",  {31'd0, lap_lost},  {31'd0, m_lost});
  endtask

  task automatic step(input int unsigned p);
    start    = (p & P_START) != 0;
    stop     = (p & P_STOP)  != 0;
    clear    = (p & P_CLEAR) != 0;
    lap      = (p & P_LAP)   != 0;
    lap_rd   = (p & P_RD)    != 0;
    min_inc  = (p & P_MIN)   != 0;
    hour_inc = (p & P_HOUR)  != 0;
    @(posedge clk);
    m_edge(p, cd_mode);
    #1;
    {start, stop, clear, lap, lap_rd, min_inc, hour_inc} = '0;
    check_all();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  logic [31:0] exp_lap [4];
  int unsigned rp;

  initial begin
    rst_n = 1'b0;
    cd_mode = 1'b0;
    {start, stop, clear, lap, lap_rd, min_inc, hour_inc} = '0;
    m_reset();
    #12;
    check_all();
    chk("reset_lap_empty", {31'd0, lap_empty}, 32'd1);
    chk("reset_running", {31'd0, running}, 32'd0);
    #8 rst_n = 1'b1;
    step(0);

    // T1: first tick DIV cycles after start, 1 s after 1000 cycles
    step(P_START);
    run_cycles(DIV - 1);
    chk("t1_cc_before_tick", {24'd0, centisec}, 32'h00);
    step(0);
    chk("t1_cc_first_tick", {24'd0, centisec}, 32'h01);
    run_cycles(990);
    chk("t1_ss_1s", {24'd0, seconds}, 32'h01);
    chk("t1_cc_1s", {24'd0, centisec}, 32'h00);

    // Asynchronous reset mid-count clears without a clock edge
    step(P_LAP);
    run_cycles(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seconds", {24'd0, seconds}, 32'h00);
    chk("arst_running", {31'd0, running}, 32'd0);
    chk("arst_lap_empty", {31'd0, lap_empty}, 32'd1);
    chk("arst_lap_data", lap_data, 32'd0);
    m_reset();
    #1 rst_n = 1'b1;
    step(0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rp = 0;
      if ($urandom_range(11) == 0) rp |= P_START;
      if ($urandom_range(15) == 0) rp |= P_STOP;
      if ($urandom_range(79) == 0) rp |= P_CLEAR;
      if ($urandom_range(5)  == 0) rp |= P_LAP;
      if ($urandom_range(6)  == 0) rp |= P_RD;
      if ($urandom_range(7)  == 0) rp |= P_MIN;
      if ($urandom_range(9)  == 0) rp |= P_HOUR;
      if ($urandom_range(19) == 0) cd_mode = ~cd_mode;
      if (m_st == ST_PAUSE && cd_mode && m_zero()) rp &= ~P_START;
      step(rp);
    end

    // T2: preset 01:59:59.99 then count-up wrap
    step(P_CLEAR);
    cd_mode = 1'b1;
    step(P_HOUR);
    step(P_START);
    run_cycles(DIV);
    step(P_STOP);
    chk("t2_mm_59", {24'd0, minutes}, 32'h59);
    step(P_HOUR);
    cd_mode = 1'b0;
    step(P_START);
    run_cycles(DIV - 1);
    chk("t2_pre_cc", {24'd0, centisec}, 32'h99);
    chk("t2_pre_hh", {24'd0, hours}, 32'h01);
    step(0);
    chk("t2_wrap_time", {hours, minutes, seconds, centisec}, 32'h0);
    chk("t2_ovf", {31'd0, ovf}, 32'd1);
    chk("t2_running", {31'd0, running}, 32'd1);

    // T3: countdown 1 minute to alarm
    step(P_CLEAR);
    chk("t3_ovf_cleared", {31'd0, ovf}, 32'd0);
    cd_mode = 1'b1;
    step(P_MIN);
    step(P_START);
    cd_mode = 1'b0;
    run_cycles(6000 * DIV - 1);
    chk("t3_pre_cc", {24'd0, centisec}, 32'h01);
    chk("t3_pre_alarm", {31'd0, alarm}, 32'd0);
    step(0);
    chk("t3_zero", {hours, minutes, seconds, centisec}, 32'h0);
    chk("t3_alarm", {31'd0, alarm}, 32'd1);
    chk("t3_running", {31'd0, running}, 32'd0);
    run_cycles(2 * DIV);
    step(P_STOP);
    chk("t3_alarm_drop", {31'd0, alarm}, 32'd0);

    // T4: overfill FIFO then drain in order
    step(P_CLEAR);
    step(P_START);
    for (int i = 0; i < 5; i++) begin
      run_cycles(DIV - 1);
      step(P_LAP);
    end
    step(P_STOP);
    chk("t4_count", {29'd0, lap_count}, 32'd4);
    chk("t4_full", {31'd0, lap_full}, 32'd1);
    chk("t4_lost", {31'd0, lap_lost}, 32'd1);
    exp_lap = '{32'h0, 32'h1, 32'h2, 32'h3};
    for (int i = 0; i < 4; i++) begin
      chk("t4_pop_data", lap_data, exp_lap[i]);
      step(P_RD);
    end
    chk("t4_empty", {31'd0, lap_empty}, 32'd1);
    step(P_RD);
    chk("t4_rd_empty", {29'd0, lap_count}, 32'd0);

    // T5: push+pop on a full FIFO
    step(P_CLEAR);
    step(P_START);
    for (int i = 0; i < 4; i++) begin
      run_cycles(DIV - 1);
      step(P_LAP);
    end
    chk("t5_full", {31'd0, lap_full}, 32'd1);
    run_cycles(DIV - 1);
    step(P_LAP | P_RD);
    chk("t5_count", {29'd0, lap_count}, 32'd4);
    chk("t5_lost", {31'd0, lap_lost}, 32'd0);
    exp_lap = '{32'h1, 32'h2, 32'h3, 32'h4};
    step(P_STOP);
    for (int i = 0; i < 4; i++) begin
      chk("t5_pop_data", lap_data, exp_lap[i]);
      step(P_RD);
    end

    // T6: countdown start at zero, inc ignored in RUN, clear on a tick edge
    step(P_CLEAR);
    cd_mode = 1'b1;
    step(P_START);
    chk("t6_stay_idle", {31'd0, running}, 32'd0);
    cd_mode = 1'b0;
    step(P_START);
    step(P_MIN | P_HOUR);
    chk("t6_inc_ignored", {16'd0, hours, minutes}, 32'h0);
    run_cycles(DIV - 2);
    chk("t6_running", {31'd0, running}, 32'd1);
    step(P_CLEAR | P_LAP);
    chk("t6_clear_time", {hours, minutes, seconds, centisec}, 32'h0);
    chk("t6_clear_idle", {31'd0, running}, 32'd0);
    run_cycles(2 * DIV);
    chk("t6_idle_hold", {24'd0, centisec}, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
